ddy_obegi: RTL and testbench
============================

Name: ddy_obegi

Overview:
- Control/status register (CSR) file directly downstream of the writeback stage.
- Consumes the writeback stage's CSR write port: write strobe, 12-bit CSR address, 32-bit data.
- Maintains the 64-bit cycle and retired-instruction counters.
- Provides a combinational read port to the execute stage.

Parameters:
- HART_KIMLIK, 32'h0000_0000, value returned by mhartid (0xF14).
- MTVEC_BASLANGIC, 32'h0000_0000, reset value of mtvec.
- MISA_DEGER, 32'h4000_0100, constant returned by misa (0x301); RV32I.

Ports:
- clk_g  input  1  clock; all state updates on rising edge.
- rst_g  input  1  asynchronous, active-high reset.
- ddy_yaz_g  input  1  CSR write strobe from writeback.
- ddy_yaz_hedef_g  input  12  CSR address for write.
- ddy_yaz_veri_g  input  32  CSR write data.
- yoy_gecerli_g  input  1  one valid instruction retiring this cycle; increments minstret.
- ddy_oku_adres_g  input  12  CSR read address from execute.
- ddy_oku_veri_c  output  32  read data, combinational.
- ddy_oku_gecersiz_c  output  1  read address unimplemented, combinational.
- ddy_mtvec_c  output  32  current mtvec, registered value.
- ddy_mepc_c  output  32  current mepc, registered value.
- ddy_mie_c  output  1  mstatus.MIE.

Behaviour:
- Reset (async, immediate) values:
  - mcycle = 0, minstret = 0, mscratch = 0, mepc = 0, mcause = 0.
  - mstatus.MIE = 0, mstatus.MPIE = 0.
  - mtvec = MTVEC_BASLANGIC.
  - Outputs follow their registers; ddy_mtvec_c = MTVEC_BASLANGIC, ddy_mepc_c = 0, ddy_mie_c = 0.
- Counters free-run from the first edge after rst_g falls.
- Implemented map; R = read-only, RW = read/write:
  - mstatus 0x300 RW: only bit3 MIE and bit7 MPIE stored; all other bits read 0, writes to them dropped.
  - misa 0x301 R.
  - mtvec 0x305 RW: bits[1:0] forced to 0 on write.
  - mscratch 0x340 RW.
  - mepc 0x341 RW: bits[1:0] forced to 0.
  - mcause 0x342 RW.
  - mcycle 0xB00 / mcycleh 0xB80 RW.
  - minstret 0xB02 / minstreth 0xB82 RW.
  - cycle 0xC00, time 0xC01, instret 0xC02, cycleh 0xC80, timeh 0xC81, instreth 0xC82: R shadows; time = mcycle.
  - mhartid 0xF14 R.
- Read port, purely combinational, zero latency:
  - Unimplemented address: ddy_oku_veri_c = 0, ddy_oku_gecersiz_c = 1.
  - Implemented address: ddy_oku_gecersiz_c = 0.
- Write port, single cycle:
  - When ddy_yaz_g = 1, the target updates on the edge.
  - Writes to R or unimplemented addresses are ignored; no state change.
- No read/write bypass. A read and write to the same address in one cycle returns the pre-write value. The new value is visible from the next cycle.
- mcycle: +1 every cycle, 64-bit, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
- minstret: +1 on cycles with yoy_gecerli_g = 1, 64-bit wrap.
- Counter write precedence (same rules for minstret/minstreth):
  - Write to low half: low = data, high holds, no increment or carry that cycle.
  - Write to high half: high = data; low increments normally; carry out of low is discarded that cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clock; a pending write is lost.

Test Plan:
- Reset then idle 10 cycles, read 0xB00 -> 10; read 0xC01 -> 10; read 0xB80 -> 0; ddy_mtvec_c = MTVEC_BASLANGIC.
- Write 0x305 data 0x8000_0103 -> next cycle ddy_mtvec_c = 0x8000_0100. Same-cycle read of 0x305 -> old value.
- Write mcycle = 0xFFFF_FFFE, mcycleh = 0 on consecutive cycles, then idle:
  - read sequence shows low wrap 0xFFFF_FFFF -> 0x0000_0000;
  - mcycleh goes 0 -> 1 on the wrap cycle.
- yoy_gecerli_g pulsed 5 times in 12 cycles, read 0xB02 -> 5 and 0xC02 -> 5. Write 0xC02 = 0x1234 -> ignored; value stays 5.
- Write 0x300 = 0xFFFF_FFFF -> read 0x300 = 0x0000_0088, ddy_mie_c = 1. Read 0x7C0 -> data 0, gecersiz 1. Read 0xF14 -> HART_KIMLIK.
- Assert rst_g between clock edges after writing mscratch = 0xDEAD_BEEF -> immediate read 0x340 = 0; counters 0.

Source files
------------

// File: rtl/ddy_obegi.sv
`default_nettype none
// ==========================================================================
// ddy_obegi : machine-mode CSR file with 64-bit cycle/instret counters
// Revision  : 1.0
// ==========================================================================
module ddy_obegi #(
  parameter logic [31:0] HART_KIMLIK     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_BASLANGIC = 32'h0000_0000,
  parameter logic [31:0] MISA_DEGER      = 32'h4000_0100
) (
  input  logic        clk_g,
  input  logic        rst_g,
  input  logic        ddy_yaz_g,
  input  logic [11:0] ddy_yaz_hedef_g,
  input  logic [31:0] ddy_yaz_veri_g,
  input  logic        yoy_gecerli_g,
  input  logic [11:0] ddy_oku_adres_g,
  output logic [31:0] ddy_oku_veri_c,
  output logic        ddy_oku_gecersiz_c,
  output logic [31:0] ddy_mtvec_c,
  output logic [31:0] ddy_mepc_c,
  output logic        ddy_mie_c
);

  localparam logic [11:0] C_MSTATUS   = 12'h300;
  localparam logic [11:0] C_MISA      = 12'h301;
  localparam logic [11:0] C_MTVEC     = 12'h305;
  localparam logic [11:0] C_MSCRATCH  = 12'h340;
  localparam logic [11:0] C_MEPC      = 12'h341;
  localparam logic [11:0] C_MCAUSE    = 12'h342;
  localparam logic [11:0] C_MCYCLE    = 12'hB00;
  localparam logic [11:0] C_MINSTRET  = 12'hB02;
  localparam logic [11:0] C_MCYCLEH   = 12'hB80;
  localparam logic [11:0] C_MINSTRETH = 12'hB82;
  localparam logic [11:0] C_CYCLE     = 12'hC00;
  localparam logic [11:0] C_TIME      = 12'hC01;
  localparam logic [11:0] C_INSTRET   = 12'hC02;
  localparam logic [11:0] C_CYCLEH    = 12'hC80;
  localparam logic [11:0] C_TIMEH     = 12'hC81;
  localparam logic [11:0] C_INSTRETH  = 12'hC82;
  localparam logic [11:0] C_MHARTID   = 12'hF14;

  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;

  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, yoy_gecerli_g};
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtvec_d    = mtvec_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    if (ddy_yaz_g) begin
      case (ddy_yaz_hedef_g)
        C_MSTATUS: begin
          mie_d  = ddy_yaz_veri_g[3];
          mpie_d = ddy_yaz_veri_g[7];
        end
        C_MTVEC:    mtvec_d    = {ddy_yaz_veri_g[31:2], 2'b00};
        C_MSCRATCH: mscratch_d = ddy_yaz_veri_g;
        C_MEPC:     mepc_d     = {ddy_yaz_veri_g[31:2], 2'b00};
        C_MCAUSE:   mcause_d   = ddy_yaz_veri_g;
        // Low-half write freezes the counter; high-half write drops the low carry.
        C_MCYCLE:   mcycle_d   = {mcycle_q[63:32], ddy_yaz_veri_g};
        C_MCYCLEH:  mcycle_d   = {ddy_yaz_veri_g, mcycle_q[31:0] + 32'd1};
        C_MINSTRET: minstret_d = {minstret_q[63:32], ddy_yaz_veri_g};
        C_MINSTRETH: minstret_d = {ddy_yaz_veri_g,
                                   minstret_q[31:0] + {31'd0, yoy_gecerli_g}};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtvec_q    <= MTVEC_BASLANGIC;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtvec_q    <= mtvec_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
    end
  end

  always_comb begin
    ddy_oku_veri_c     = 32'd0;
    ddy_oku_gecersiz_c = 1'b0;
    case (ddy_oku_adres_g)
      C_MSTATUS:                   ddy_oku_veri_c = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
      C_MISA:                      ddy_oku_veri_c = MISA_DEGER;
      C_MTVEC:                     ddy_oku_veri_c = mtvec_q;
      C_MSCRATCH:                  ddy_oku_veri_c = mscratch_q;
      C_MEPC:                      ddy_oku_veri_c = mepc_q;
      C_MCAUSE:                    ddy_oku_veri_c = mcause_q;
      C_MCYCLE, C_CYCLE, C_TIME:   ddy_oku_veri_c = mcycle_q[31:0];
      C_MCYCLEH, C_CYCLEH, C_TIMEH: ddy_oku_veri_c = mcycle_q[63:32];
      C_MINSTRET, C_INSTRET:       ddy_oku_veri_c = minstret_q[31:0];
      C_MINSTRETH, C_INSTRETH:     ddy_oku_veri_c = minstret_q[63:32];
      C_MHARTID:                   ddy_oku_veri_c = HART_KIMLIK;
      default:                     ddy_oku_gecersiz_c = 1'b1;
    endcase
  end

  assign ddy_mtvec_c = mtvec_q;
  assign ddy_mepc_c  = mepc_q;
  assign ddy_mie_c   = mie_q;

endmodule
`default_nettype wire

// File: tb/tb_ddy_obegi.sv
`default_nettype none
// ==========================================================================
// tb_ddy_obegi : directed checks of the ddy_obegi CSR file
// Revision     : 1.0
// ==========================================================================
module tb_ddy_obegi;

  localparam logic [31:0] HART     = 32'h0000_0000;
  localparam logic [31:0] MTVEC_RV = 32'h0000_0000;
  localparam logic [31:0] MISA     = 32'h4000_0100;

  logic        clk_g = 1'b0;
  logic        rst_g;
  logic        ddy_yaz_g;
  logic [11:0] ddy_yaz_hedef_g;
  logic [31:0] ddy_yaz_veri_g;
  logic        yoy_gecerli_g;
  logic [11:0] ddy_oku_adres_g;
  logic [31:0] ddy_oku_veri_c;
  logic        ddy_oku_gecersiz_c;
  logic [31:0] ddy_mtvec_c;
  logic [31:0] ddy_mepc_c;
  logic        ddy_mie_c;

  int vectors = 0;
  int miscompares = 0;

  ddy_obegi #(
    .HART_KIMLIK(HART), .MTVEC_BASLANGIC(MTVEC_RV), .MISA_DEGER(MISA)
  ) dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .ddy_yaz_g(ddy_yaz_g), .ddy_yaz_hedef_g(ddy_yaz_hedef_g),
    .ddy_yaz_veri_g(ddy_yaz_veri_g), .yoy_gecerli_g(yoy_gecerli_g),
    .ddy_oku_adres_g(ddy_oku_adres_g), .ddy_oku_veri_c(ddy_oku_veri_c),
    .ddy_oku_gecersiz_c(ddy_oku_gecersiz_c), .ddy_mtvec_c(ddy_mtvec_c),
    .ddy_mepc_c(ddy_mepc_c), .ddy_mie_c(ddy_mie_c)
  );

  always #5 clk_g = ~clk_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [11:0] adr, input logic [31:0] exp);
    ddy_oku_adres_g = adr;
    #1;
    chk(tag, ddy_oku_veri_c, exp);
  endtask

  task automatic tick();
    @(posedge clk_g);
    #1;
  endtask

  task automatic wr(input logic [11:0] adr, input logic [31:0] dat);
    ddy_yaz_g       = 1'b1;
    ddy_yaz_hedef_g = adr;
    ddy_yaz_veri_g  = dat;
  endtask

  logic [11:0] yoy_pat;

  initial begin
    rst_g = 1'b1;
    ddy_yaz_g = 1'b0;
    ddy_yaz_hedef_g = 12'h000;
    ddy_yaz_veri_g = 32'h0;
    yoy_gecerli_g = 1'b0;
    ddy_oku_adres_g = 12'hB00;
    #12;
    rst_g = 1'b0;
    #1;
    chk("rst_mtvec", ddy_mtvec_c, MTVEC_RV);
    chk("rst_mepc", ddy_mepc_c, 32'h0);
    chk("rst_mie", {31'd0, ddy_mie_c}, 32'h0);
    rd("rst_mcycle", 12'hB00, 32'h0);

    repeat (10) tick();
    rd("mcycle_10", 12'hB00, 32'd10);
    rd("time_10", 12'hC01, 32'd10);
    rd("mcycleh_0", 12'hB80, 32'd0);
    chk("mtvec_idle", ddy_mtvec_c, MTVEC_RV);

    wr(12'h305, 32'h8000_0103);
    rd("mtvec_same_cycle", 12'h305, MTVEC_RV);
    tick();
    ddy_yaz_g = 1'b0;
    chk("mtvec_out", ddy_mtvec_c, 32'h8000_0100);
    rd("mtvec_rd", 12'h305, 32'h8000_0100);

    wr(12'hB00, 32'hFFFF_FFFE);
    tick();
    wr(12'hB80, 32'h0);
    rd("mcycle_lo_written", 12'hB00, 32'hFFFF_FFFE);
    tick();
    ddy_yaz_g = 1'b0;
    rd("mcycle_ffff", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycleh_pre_wrap", 12'hB80, 32'h0);
    tick();
    rd("mcycle_wrap", 12'hB00, 32'h0);
    rd("mcycleh_wrap", 12'hB80, 32'h1);
    rd("cycleh_wrap", 12'hC80, 32'h1);

    // High-half write on the cycle the low half overflows: carry dropped.
    wr(12'hB00, 32'hFFFF_FFFF);
    tick();
    wr(12'hB80, 32'h7);
    tick();
    ddy_yaz_g = 1'b0;
    rd("mcycle_carry_lo", 12'hB00, 32'h0);
    rd("mcycle_carry_hi", 12'hB80, 32'h7);
    tick();
    rd("mcycle_after_hi", 12'hB00, 32'h1);

    yoy_pat = 12'b1010_0101_0001;
    for (int i = 0; i < 12; i++) begin
      yoy_gecerli_g = yoy_pat[i];
      tick();
    end
    yoy_gecerli_g = 1'b0;
    rd("minstret_5", 12'hB02, 32'd5);
    rd("instret_5", 12'hC02, 32'd5);
    rd("instreth_0", 12'hC82, 32'd0);
    wr(12'hC02, 32'h1234);
    tick();
    ddy_yaz_g = 1'b0;
    rd("instret_ro", 12'hC02, 32'd5);
    rd("minstret_ro", 12'hB02, 32'd5);

    wr(12'hB02, 32'h0000_0100);
    yoy_gecerli_g = 1'b1;
    tick();
    ddy_yaz_g = 1'b0;
    yoy_gecerli_g = 1'b0;
    rd("minstret_lo_wr", 12'hB02, 32'h0000_0100);

    wr(12'h300, 32'hFFFF_FFFF);
    tick();
    ddy_yaz_g = 1'b0;
    rd("mstatus", 12'h300, 32'h0000_0088);
    chk("mie_out", {31'd0, ddy_mie_c}, 32'h1);
    rd("unimpl_data", 12'h7C0, 32'h0);
    chk("unimpl_flag", {31'd0, ddy_oku_gecersiz_c}, 32'h1);
    rd("mhartid", 12'hF14, HART);
    chk("mhartid_flag", {31'd0, ddy_oku_gecersiz_c}, 32'h0);
    rd("misa", 12'h301, MISA);

    wr(12'h341, 32'h1234_5677);
    tick();
    ddy_yaz_g = 1'b0;
    chk("mepc_out", ddy_mepc_c, 32'h1234_5674);
    wr(12'h342, 32'h8000_000B);
    tick();
    ddy_yaz_g = 1'b0;
    rd("mcause", 12'h342, 32'h8000_000B);

    wr(12'h340, 32'hDEAD_BEEF);
    tick();
    wr(12'h341, 32'h0000_0044);
    rd("mscratch", 12'h340, 32'hDEAD_BEEF);
    #1;
    rst_g = 1'b1;
    rd("rst_mscratch", 12'h340, 32'h0);
    rd("rst_mcycle_mid", 12'hB00, 32'h0);
    rd("rst_minstret_mid", 12'hB02, 32'h0);
    chk("rst_mie_mid", {31'd0, ddy_mie_c}, 32'h0);
    chk("rst_mtvec_mid", ddy_mtvec_c, MTVEC_RV);
    tick();
    chk("rst_pending_wr", ddy_mepc_c, 32'h0);
    ddy_yaz_g = 1'b0;
    rst_g = 1'b0;
    tick();
    rd("post_rst_mcycle", 12'hB00, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
